ahb_spi_slave: RTL

AHB_SPI_SLAVE -- requirements
Module: ahb_spi_slave

---
 rtl/ahb_spi_slave_pkg.sv | 22 ++
 rtl/spi_sync.sv | 26 ++
 rtl/ahb_spi_slave.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/ahb_spi_slave_pkg.sv
// Shared definitions for the AHB-attached SPI slave: register map, bit positions, defaults.
package ahb_spi_slave_pkg;

  typedef enum logic [1:0] {
    RegStatus = 2'b00,
    RegTxdata = 2'b01,
    RegRxdata = 2'b10,
    RegCtrl   = 2'b11
  } reg_addr_e;

  localparam int unsigned STAT_RXVALID  = 0;
  localparam int unsigned STAT_OVERRUN  = 1;
  localparam int unsigned STAT_TXEMPTY  = 2;
  localparam int unsigned STAT_SELECTED = 3;
  localparam int unsigned STAT_BUSY     = 7;

  localparam int unsigned CTRL_EN    = 0;
  localparam int unsigned CTRL_IRQEN = 1;

  localparam logic [7:0] IDLE_FILL_DEFAULT = 8'h00;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchroniser for a single asynchronous input, with a configurable idle value.
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/ahb_spi_slave.sv
// AHB-Lite register front end for an SPI mode-0 slave with one-byte TX buffer and RX holding reg.
module ahb_spi_slave
  import ahb_spi_slave_pkg::*;
#(
  parameter logic [7:0] IDLE_FILL = IDLE_FILL_DEFAULT
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  input  logic        SCLK,
  input  logic        MOSI,
  input  logic        SS_N,
  output logic        MISO,
  output logic        MISO_OE,
  output logic        IRQ
);

  logic w_sclk, w_mosi, w_ss_n;
  logic r_sclk_prev, r_ss_prev;

  spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (.i_clk(HCLK), .i_rst_n(HRESETn), .i_d(SCLK), .o_q(w_sclk));
  spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (.i_clk(HCLK), .i_rst_n(HRESETn), .i_d(MOSI), .o_q(w_mosi));
  spi_sync #(.RST_VAL(1'b1)) u_sync_ss   (.i_clk(HCLK), .i_rst_n(HRESETn), .i_d(SS_N), .o_q(w_ss_n));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_sclk_prev <= 1'b0;
      r_ss_prev   <= 1'b1;
    end else begin
      r_sclk_prev <= w_sclk;
      r_ss_prev   <= w_ss_n;
    end
  end

  reg_addr_e   r_addr;
  logic        r_wr, r_rd;
  logic [1:0]  r_ctrl;
  logic [7:0]  r_tx_buf, r_tx_shift, r_rx_shift, r_rxdata;
  logic        r_txempty, r_rxvalid, r_overrun, r_reload, r_irq;
  logic [2:0]  r_cnt;

  logic       w_selected, w_sclk_rise, w_sclk_fall, w_ss_fall;
  logic       w_byte_done, w_tx_load, w_busy;
  logic       w_wr_tx, w_wr_stat, w_wr_ctrl, w_rd_rx;
  logic [7:0] w_rx_byte, w_tx_next, w_status;

  assign w_selected  = r_ctrl[CTRL_EN] & ~w_ss_n;
  assign w_sclk_rise = w_sclk & ~r_sclk_prev;
  assign w_sclk_fall = ~w_sclk & r_sclk_prev;
  assign w_ss_fall   = w_selected & r_ss_prev;
  assign w_byte_done = w_selected & w_sclk_rise & (r_cnt == 3'd7);
  assign w_rx_byte   = {r_rx_shift[6:0], w_mosi};
  // Reload at frame start, and on the first falling edge after a completed byte.
  assign w_tx_load   = w_ss_fall | (w_selected & w_sclk_fall & r_reload);
  assign w_tx_next   = r_txempty ? IDLE_FILL : r_tx_buf;
  assign w_busy      = w_selected & (r_cnt != 3'd0);

  assign w_wr_tx   = r_wr & (r_addr == RegTxdata);
  assign w_wr_stat = r_wr & (r_addr == RegStatus);
  assign w_wr_ctrl = r_wr & (r_addr == RegCtrl);
  assign w_rd_rx   = r_rd & (r_addr == RegRxdata);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_addr <= RegStatus;
      r_wr   <= 1'b0;
      r_rd   <= 1'b0;
    end else if (HREADY) begin
      r_addr <= reg_addr_e'(HADDR[3:2]);
      r_wr   <= HSEL & HWRITE & HTRANS[1];
      r_rd   <= HSEL & ~HWRITE & HTRANS[1];
    end
  end

  // Deselection (SS_N high or EN low) aborts any partial byte.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_cnt      <= 3'd0;
      r_reload   <= 1'b0;
      r_rx_shift <= 8'h00;
      r_tx_shift <= 8'h00;
    end else if (!w_selected) begin
      r_cnt      <= 3'd0;
      r_reload   <= 1'b0;
      r_rx_shift <= 8'h00;
    end else begin
      if (w_sclk_rise) begin
        r_rx_shift <= w_rx_byte;
        r_cnt      <= r_cnt + 3'd1;
        r_reload   <= (r_cnt == 3'd7);
      end
      if (w_tx_load) begin
        r_tx_shift <= w_tx_next;
        r_reload   <= 1'b0;
      end else if (w_sclk_fall) begin
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      end
    end
  end

  // A CPU write coinciding with a load wins: the load already used the old buffer.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_tx_buf  <= 8'h00;
      r_txempty <= 1'b1;
    end else begin
      if (w_tx_load) r_txempty <= 1'b1;
      if (w_wr_tx) begin
        r_tx_buf  <= HWDATA[7:0];
        r_txempty <= 1'b0;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_rxdata  <= 8'h00;
      r_rxvalid <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr_stat && HWDATA[STAT_OVERRUN]) r_overrun <= 1'b0;
      if (w_byte_done) begin
        if (r_rxvalid && !w_rd_rx) begin
          r_overrun <= 1'b1;
        end else begin
          r_rxdata  <= w_rx_byte;
          r_rxvalid <= 1'b1;
        end
      end else if (w_rd_rx) begin
        r_rxvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_ctrl <= 2'b00;
      r_irq  <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_ctrl <= HWDATA[1:0];
      r_irq <= r_ctrl[CTRL_IRQEN] & (r_rxvalid | r_overrun);
    end
  end

  always_comb begin
    w_status                = 8'h00;
    w_status[STAT_BUSY]     = w_busy;
    w_status[STAT_SELECTED] = w_selected;
    w_status[STAT_TXEMPTY]  = r_txempty;
    w_status[STAT_OVERRUN]  = r_overrun;
    w_status[STAT_RXVALID]  = r_rxvalid;
  end

  always_comb begin
    HRDATA = 32'h0;
    unique case (r_addr)
      RegStatus: HRDATA[7:0] = w_status;
      RegTxdata: HRDATA[7:0] = r_tx_buf;
      RegRxdata: HRDATA[7:0] = r_rxdata;
      RegCtrl:   HRDATA[7:0] = {6'b0, r_ctrl};
      default:   HRDATA      = 32'h0;
    endcase
  end

  assign HREADYOUT = 1'b1;
  assign MISO_OE   = w_selected;
  assign MISO      = w_selected & r_tx_shift[7];
  assign IRQ       = r_irq;

  logic w_unused;
  assign w_unused = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:8]};

endmodule
